// File: rtl/ajc_status_cond_unit_v.sv
// CNVZ status register with branch-condition evaluation and a flag save/restore stack.
// Define AJC_COND_REG_EN to register Cond_True (one cycle of latency, resets to 0).
module ajc_status_cond_unit_v #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Flag_In,
  input  logic [3:0] Flag_WE,
  input  logic [3:0] Cond_Sel,
  input  logic       Push,
  input  logic       Pop,
  input  logic       Err_Clr,
  output logic [3:0] Flags_Out,
  output logic       Cond_True,
  output logic       Stack_Full,
  output logic       Stack_Empty,
  output logic       Stack_Err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [3:0]    stk_q [STACK_DEPTH];
  logic [3:0]    stk_d [STACK_DEPTH];

  logic          full, empty;
  logic          push_only, pop_only;
  logic          do_push, do_pop, err_set;
  logic [CW-1:0] cnt_m1;
  logic [IW-1:0] push_idx, pop_idx;
  logic [3:0]    wr_flags;
  logic          cond_c;
  logic          c_f, n_f, v_f, z_f;

  assign full      = (cnt_q == CW'(STACK_DEPTH));
  assign empty     = (cnt_q == '0);
  assign push_only = Push & ~Pop;
  assign pop_only  = Pop & ~Push;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only & ~empty;
  assign err_set   = (push_only & full) | (pop_only & empty);
  assign cnt_m1    = cnt_q - CW'(1);
  assign push_idx  = cnt_q[IW-1:0];
  assign pop_idx   = cnt_m1[IW-1:0];
  assign wr_flags  = (flags_q & ~Flag_WE) | (Flag_In & Flag_WE);

  always_comb begin
    flags_d = wr_flags;
    cnt_d   = cnt_q;
    stk_d   = stk_q;
    if (do_push) begin
      stk_d[push_idx] = flags_q;
      cnt_d           = cnt_q + CW'(1);
    end else if (do_pop) begin
      flags_d = stk_q[pop_idx];
      cnt_d   = cnt_m1;
    end else if (pop_only) begin
      // underflow: the failed pop also suppresses the flag write
      flags_d = flags_q;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (Err_Clr) begin
      err_d = 1'b0;
    end
  end

  assign c_f = flags_q[3];
  assign n_f = flags_q[2];
  assign v_f = flags_q[1];
  assign z_f = flags_q[0];

  always_comb begin
    cond_c = 1'b0;
    case (Cond_Sel)
      4'd0:    cond_c = 1'b1;
      4'd1:    cond_c = z_f;
      4'd2:    cond_c = ~z_f;
      4'd3:    cond_c = c_f;
      4'd4:    cond_c = ~c_f;
      4'd5:    cond_c = n_f;
      4'd6:    cond_c = ~n_f;
      4'd7:    cond_c = v_f;
      4'd8:    cond_c = ~v_f;
      4'd9:    cond_c = n_f ^ v_f;
      4'd10:   cond_c = ~(n_f ^ v_f);
      4'd11:   cond_c = c_f & ~z_f;
      4'd12:   cond_c = ~c_f | z_f;
      4'd13:   cond_c = ~z_f & ~(n_f ^ v_f);
      4'd14:   cond_c = z_f | (n_f ^ v_f);
      default: cond_c = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      flags_q <= 4'b0000;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // stack contents are don't-care after reset, so no reset term
  always_ff @(posedge Clock) begin
    stk_q <= stk_d;
  end

`ifdef AJC_COND_REG_EN
  logic cond_q, cond_d;

  assign cond_d = cond_c;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cond_q <= 1'b0;
    end else begin
      cond_q <= cond_d;
    end
  end

  assign Cond_True = cond_q;
`else
  assign Cond_True = cond_c;
`endif

  assign Flags_Out   = flags_q;
  assign Stack_Full  = full;
  assign Stack_Empty = empty;
  assign Stack_Err   = err_q;

endmodule

// File: doc/ajc_status_cond_unit_v.md
AJC_STATUS_COND_UNIT_V -- requirements
Module: ajc_status_cond_unit_v

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, number of flag save/restore entries (legal 2..16).
REQ-002 SHALL have port Clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Flag_In, input, 4, CNVZ flags from a functional unit; bit 3 is C, bit 2 N, bit 1 V, bit 0 Z.
REQ-005 SHALL have port Flag_WE, input, 4, per-bit write mask aligned with Flag_In.
REQ-006 SHALL have port Cond_Sel, input, 4, branch condition code.
REQ-007 SHALL have ports Push and Pop, input, 1 each, save/restore flag requests.
REQ-008 SHALL have port Err_Clr, input, 1, clears Stack_Err.
REQ-009 SHALL have port Flags_Out, output, 4, registered CNVZ.
REQ-010 SHALL have port Cond_True, output, 1, result of Cond_Sel evaluated on Flags_Out.
REQ-011 SHALL have ports Stack_Full, Stack_Empty, Stack_Err, output, 1 each.

Function
REQ-012 SHALL update Flags_Out[i] <= Flag_In[i] on the next edge for every i with Flag_WE[i]=1; bits with Flag_WE[i]=0 are held.
REQ-013 SHALL evaluate Cond_Sel as: 0 always, 1 Z, 2 ~Z, 3 C, 4 ~C, 5 N, 6 ~N, 7 V, 8 ~V, 9 N^V, 10 ~(N^V), 11 C&~Z, 12 ~C|Z, 13 ~Z&~(N^V), 14 Z|(N^V), 15 never.
REQ-014 SHALL, on Push with stack not full, write the pre-edge Flags_Out to the top entry and increment the pointer; any Flag_WE write in the same cycle still applies to Flags_Out.
REQ-015 SHALL, on Pop with stack not empty, load Flags_Out from the top entry and decrement the pointer; Pop overrides Flag_WE in the same cycle.
REQ-016 SHALL treat Push and Pop in the same cycle as a stack no-op: the pointer is unchanged and Stack_Err is unchanged; Flag_WE applies.
REQ-017 SHALL, on Push when full, leave the stack unchanged and set Stack_Err.
REQ-018 SHALL, on Pop when empty, leave the stack and Flags_Out unchanged, ignore Flag_WE for that cycle, and set Stack_Err.
REQ-019 SHALL keep Stack_Err sticky until Err_Clr; if a new error and Err_Clr occur in the same cycle, the set wins.
REQ-020 SHALL drive Stack_Full when the count is STACK_DEPTH and Stack_Empty when the count is 0, both decoded from registered count.
REQ-021 SHALL use a count register of width clog2(STACK_DEPTH+1) with no wrap-around beyond 0..STACK_DEPTH.

Reset
REQ-022 SHALL, on Reset, set Flags_Out=4'b0000, count=0, Stack_Empty=1, Stack_Full=0, Stack_Err=0, Cond_True per REQ-013/REQ-024 on zero flags; stack entry contents are don't-care.
REQ-023 SHALL abort any in-progress Push/Pop when Reset asserts mid-cycle; the first post-reset edge honours inputs normally.

Configuration
REQ-024 SHALL, when macro AJC_COND_REG_EN is defined, register Cond_True (one-cycle latency from Cond_Sel/Flags_Out, reset value 0); when undefined, Cond_True is combinational with zero latency.

Verification
REQ-025 SHALL cover: Reset, then Flag_In=4'b1111 with Flag_WE=4'b0101 -> next cycle Flags_Out=4'b0101.
REQ-026 SHALL cover: Flags_Out=4'b0100 (N=1, V=0), Cond_Sel=9 -> Cond_True=1; Cond_Sel=13 -> 0; Cond_Sel=15 -> 0 (delayed one cycle if AJC_COND_REG_EN).
REQ-027 SHALL cover: four Pushes of 4'h1, 4'h2, 4'h3, 4'h4 -> Stack_Full=1; a fifth Push -> Stack_Err=1 with stack contents unchanged; four Pops restore 4, 3, 2, 1 -> Stack_Empty=1.
REQ-028 SHALL cover: Pop when empty with Flag_WE=4'hF -> Flags_Out unchanged and Stack_Err=1; Err_Clr -> Stack_Err=0 next cycle.
REQ-029 SHALL cover: Push, Pop and Flag_WE=4'h1 with Flag_In=4'h1 in the same cycle -> count unchanged and Flags_Out Z=1.
REQ-030 SHALL cover: Reset asserted asynchronously between edges with count=3 -> outputs reach reset values immediately, before the next edge.
